serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Bit-serial add/subtract sequencer built around a single 1-bit adder cell (two half-adder stages plus carry OR). It accepts two WIDTH-bit operands on a start strobe, processes them LSB-first one bit per clock, and presents a WIDTH-bit result with carry and signed-overflow flags. It trades area for latency in arithmetic paths where one shared adder cell is preferred over a parallel adder.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
sub  input  1  0 = A+B, 1 = A-B; captured on accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when result is valid
sum  output  WIDTH  result register
cout  output  1  carry out of MSB (add); no-borrow flag (sub: 1 means A>=B unsigned)
ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Interface: one clock clk; rst_n is asynchronous, active-low. All state is cleared immediately on rst_n=0, independent of clk.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, internal shift registers, carry and bit counter = 0.
- FSM states:
  - IDLE: waiting for work.
  - RUN: one bit processed per cycle.
  - DONE: result presented.
- Accepting start (IDLE or DONE, start=1, rising edge E0):
  - opA <= a; opB <= (sub ? ~b : b); carry <= sub; cnt <= 0; state <= RUN; busy <= 1.
- RUN, each edge:
  - s = opA[0]^opB[0]^carry; c = (opA[0]&opB[0]) | (carry&(opA[0]^opB[0])).
  - res <= {s, res[WIDTH-1:1]}; opA and opB shift right by 1; carry <= c; cnt <= cnt+1.
  - On the edge where cnt = WIDTH-2, record carry-into-MSB as c.
  - On the edge where cnt = WIDTH-1 (edge E0+WIDTH), load sum <= final shifted result, cout <= c, ovf <= c XOR carry-into-MSB; state <= DONE; busy <= 0; done <= 1.
- DONE: lasts exactly one cycle.
  - done=1 for one cycle only, then falls at edge E0+WIDTH+1.
  - Next state is IDLE, or RUN if start=1 in that cycle (back-to-back accepted; throughput is one result per WIDTH cycles).
- Latency: done and result are visible after edge E0+WIDTH, i.e. exactly WIDTH cycles after the accepting edge.
- sum, cout and ovf hold their values until the next operation completes; they are not cleared on a new start.
- start while busy=1 is ignored. The operation is not restarted and the a/b/sub inputs are not sampled.
- a, b and sub may change freely after the accepting edge without affecting the result.
- Wrap-around: the result is modulo 2^WIDTH; cout and ovf report the excess. No saturation.
- Reset mid-operation: the operation is aborted, all outputs return to their reset values, and no done pulse is issued. The first start after rst_n deasserts is accepted normally.
- Counter width: clog2(WIDTH) bits. cnt never exceeds WIDTH-1.

Test Plan:
- WIDTH=8, add a=8'h35, b=8'h4A, single-cycle start -> busy high for 8 cycles; done pulses 8 cycles after the accepting edge; sum=8'h7F, cout=0, ovf=0.
- Add edge cases: a=8'hFF, b=8'h01 -> sum=8'h00, cout=1, ovf=0. Then a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
- Subtract: a=8'h10, b=8'h20, sub=1 -> sum=8'hF0, cout=0, ovf=0. Then a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, ovf=1.
- start reasserted with a=8'h01, b=8'h01 at cycle 3 of a running 8'h35+8'h4A -> ignored; result still 8'h7F, exactly one done pulse. Then start held high in the DONE cycle with a=8'h02, b=8'h03 -> accepted; next done 8 cycles later with sum=8'h05.
- rst_n pulled low asynchronously (mid-clock) during RUN cycle 4 -> busy, done, sum, cout and ovf read 0 immediately with no clock edge; no done pulse follows. After release, a=8'h01, b=8'h02 -> sum=8'h03 after 8 cycles.
- Operands changed every cycle after the accepting edge (random values) -> result matches the operands captured at the accepting edge. Repeat with 1000 random add/sub operations against a reference model, checking sum, cout and ovf.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// serial_add_ctrl : bit-serial add/subtract sequencer on one shared 1-bit adder
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic             carry_msb;
  logic [CW-1:0]    cnt;

  logic ha_s, ha_c, bit_s, bit_c, last_bit, msb_bit;

  // Two half-adder stages plus the carry OR form the single shared adder cell.
  assign ha_s     = op_a[0] ^ op_b[0];
  assign ha_c     = op_a[0] & op_b[0];
  assign bit_s    = ha_s ^ carry;
  assign bit_c    = ha_c | (ha_s & carry);
  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign msb_bit  = (cnt == CW'(WIDTH - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      carry     <= 1'b0;
      carry_msb <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // Result bits enter at the top of op_a as operand bits leave the bottom.
          op_a  <= {bit_s, op_a[WIDTH-1:1]};
          op_b  <= {1'b0, op_b[WIDTH-1:1]};
          carry <= bit_c;
          if (msb_bit) carry_msb <= bit_c;
          if (last_bit) begin
            sum   <= {bit_s, op_a[WIDTH-1:1]};
            cout  <= bit_c;
            ovf   <= bit_c ^ carry_msb;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// tb_serial_add_ctrl : directed and random checks of the serial add/sub block
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             sub = 1'b0;
  logic             busy, done, cout, ovf;
  logic [WIDTH-1:0] sum;

  int tests = 0;
  int fails = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Independent reference: {cout, ovf, sum}
  function automatic logic [9:0] ref_op(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [8:0] r;
    logic       c, v;
    if (!s) begin
      r = {1'b0, x} + {1'b0, y};
      c = r[8];
      v = (x[7] == y[7]) && (r[7] != x[7]);
    end else begin
      r = {1'b0, x} - {1'b0, y};
      c = (x >= y);
      v = (x[7] != y[7]) && (r[7] != x[7]);
    end
    return {c, v, r[7:0]};
  endfunction

  // Present operands, take the accepting edge, return 1ns after it.
  task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic s);
    a = av; b = bv; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges from the accepting edge until done; inputs are scrambled meanwhile.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({busy, done, sum, cout, ovf} !== 12'h000) begin
      fails++;
      $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [7:0] av [3] = '{8'h35, 8'hFF, 8'h7F};
    logic [7:0] bv [3] = '{8'h4A, 8'h01, 8'h01};
    logic [9:0] ex [3] = '{{2'b00, 8'h7F}, {2'b10, 8'h00}, {2'b01, 8'h80}};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      launch(av[i], bv[i], 1'b0);
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL add_busy[%0d]: got busy=%b done=%b, want busy=1 done=0", i, busy, done);
      end
      wait_done(cyc);
      tests++;
      if (cyc !== 8 || busy !== 1'b0) begin
        fails++;
        $display("FAIL add_latency[%0d]: got %0d cycles busy=%b, want 8 cycles busy=0", i, cyc, busy);
      end
      tests++;
      if ({cout, ovf, sum} !== ex[i]) begin
        fails++;
        $display("FAIL add_result[%0d]: got cout=%b ovf=%b sum=%h, want %b %b %h",
                 i, cout, ovf, sum, ex[i][9], ex[i][8], ex[i][7:0]);
      end
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0 || {cout, ovf, sum} !== ex[i]) begin
        fails++;
        $display("FAIL add_done_fall[%0d]: got done=%b result=%h, want done=0 result=%h",
                 i, done, {cout, ovf, sum}, ex[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [7:0] av [2] = '{8'h10, 8'h80};
    logic [7:0] bv [2] = '{8'h20, 8'h01};
    logic [9:0] ex [2] = '{{2'b00, 8'hF0}, {2'b11, 8'h7F}};
    int cyc;
    for (int i = 0; i < 2; i++) begin
      launch(av[i], bv[i], 1'b1);
      wait_done(cyc);
      tests++;
      if (cyc !== 8 || {cout, ovf, sum} !== ex[i]) begin
        fails++;
        $display("FAIL sub_result[%0d]: got cyc=%0d cout=%b ovf=%b sum=%h, want cyc=8 %b %b %h",
                 i, cyc, cout, ovf, sum, ex[i][9], ex[i][8], ex[i][7:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int first  = 0;
    int cyc;
    launch(8'h35, 8'h4A, 1'b0);
    @(posedge clk); #1;
    a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 3; k <= 8; k++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    tests++;
    if (pulses !== 1 || first !== 8 || sum !== 8'h7F) begin
      fails++;
      $display("FAIL ignore_start: got pulses=%0d at=%0d sum=%h, want 1 at 8 sum=7f", pulses, first, sum);
    end
    a = 8'h02; b = 8'h03; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (done !== 1'b0 || busy !== 1'b1 || sum !== 8'h7F) begin
      fails++;
      $display("FAIL b2b_accept: got done=%b busy=%b sum=%h, want done=0 busy=1 sum=7f", done, busy, sum);
    end
    wait_done(cyc);
    tests++;
    if (cyc !== 8 || sum !== 8'h05 || cout !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL b2b_result: got cyc=%0d sum=%h cout=%b ovf=%b, want 8 05 0 0", cyc, sum, cout, ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int pulses = 0;
    int cyc;
    launch(8'h80, 8'h01, 1'b1);
    wait_done(cyc);
    @(posedge clk); #1;
    launch(8'h35, 8'h4A, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, sum, cout, ovf} !== 12'h000) begin
      fails++;
      $display("FAIL async_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    tests++;
    if (pulses !== 0) begin
      fails++;
      $display("FAIL reset_no_done: got %0d active cycles, want 0", pulses);
    end
    launch(8'h01, 8'h02, 1'b0);
    wait_done(cyc);
    tests++;
    if (cyc !== 8 || sum !== 8'h03) begin
      fails++;
      $display("FAIL post_reset: got cyc=%0d sum=%h, want 8 03", cyc, sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [7:0] x, y;
    logic       s;
    logic [9:0] ex;
    int cyc;
    for (int n = 0; n < 1000; n++) begin
      x = 8'($urandom); y = 8'($urandom); s = 1'($urandom);
      ex = ref_op(x, y, s);
      launch(x, y, s);
      wait_done(cyc);
      tests++;
      if (cyc !== 8 || {cout, ovf, sum} !== ex) begin
        fails++;
        $display("FAIL random[%0d] %h %s %h: got cyc=%0d cout=%b ovf=%b sum=%h, want 8 %b %b %h",
                 n, x, s ? "-" : "+", y, cyc, cout, ovf, sum, ex[9], ex[8], ex[7:0]);
      end
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
